// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage rv32i pipeline: load-use, taken-branch
// and multi-cycle dmem hazards, with a dmem wait timeout trap and perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       dest_EX,
  input  logic             regwen_EX,
  input  logic             memread_EX,
  input  logic             branch_taken_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  output logic             hold_IF,
  output logic             hold_ID,
  output logic             hold_EX,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic             bubble_WB,
  output logic             redirect_en,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {RUN, MWAIT, ERR} state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               mem_err_q, mem_err_d;

  logic lu, mw, frz, do_run;

  always_comb begin
    lu = memread_EX & regwen_EX & (dest_EX != 5'd0) &
         ((use_rs1_ID & (rs1_ID == dest_EX)) | (use_rs2_ID & (rs2_ID == dest_EX)));
    mw = dmem_req_MEM & ~dmem_ready;
  end

  // Next state and zero-latency pipeline controls
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    frz         = 1'b0;
    do_run      = 1'b0;
    hold_IF     = 1'b0;
    hold_ID     = 1'b0;
    hold_EX     = 1'b0;
    flush_ID    = 1'b0;
    flush_EX    = 1'b0;
    bubble_WB   = 1'b0;
    redirect_en = 1'b0;

    case (state_q)
      RUN: do_run = 1'b1;
      MWAIT: begin
        if (dmem_ready) begin
          // Release the freeze and resolve the deferred EX hazard this cycle
          do_run     = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          frz = 1'b1;
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
            state_d   = ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      ERR:     frz = 1'b1;
      default: state_d = RUN;
    endcase

    if (do_run) begin
      if (mw) begin
        frz        = 1'b1;
        state_d    = MWAIT;
        wait_cnt_d = WAIT_W'(1);
      end else if (branch_taken_EX) begin
        flush_ID    = 1'b1;
        flush_EX    = 1'b1;
        redirect_en = 1'b1;
      end else if (lu) begin
        hold_IF  = 1'b1;
        flush_EX = 1'b1;
      end
    end

    if (frz) begin
      hold_IF   = 1'b1;
      hold_ID   = 1'b1;
      hold_EX   = 1'b1;
      bubble_WB = 1'b1;
    end

    if (rst) begin
      hold_IF     = 1'b0;
      hold_ID     = 1'b0;
      hold_EX     = 1'b0;
      flush_ID    = 1'b0;
      flush_EX    = 1'b0;
      bubble_WB   = 1'b0;
      redirect_en = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold_IF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect_en && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand-written
// multi-cycle sequences and random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 4;
  localparam int          SAT = 15;

  typedef struct {
    logic [4:0] rs1, rs2, dest;
    logic       u1, u2, rw, mr, br, req, rdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        i;
    logic [7:0] exp;  // {hold_IF,hold_ID,hold_EX,flush_ID,flush_EX,bubble_WB,redirect_en,mem_err}
  } vec_t;

  logic          clk, rst;
  logic [4:0]    rs1_ID, rs2_ID, dest_EX;
  logic          use_rs1_ID, use_rs2_ID, regwen_EX, memread_EX, branch_taken_EX;
  logic          dmem_req_MEM, dmem_ready;
  logic          hold_IF, hold_ID, hold_EX, flush_ID, flush_EX, bubble_WB, redirect_en, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .dest_EX(dest_EX), .regwen_EX(regwen_EX), .memread_EX(memread_EX),
    .branch_taken_EX(branch_taken_EX), .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
    .hold_IF(hold_IF), .hold_ID(hold_ID), .hold_EX(hold_EX), .flush_ID(flush_ID),
    .flush_EX(flush_EX), .bubble_WB(bubble_WB), .redirect_en(redirect_en),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: frozen pipeline, wait length, trap flag, event counts
  bit m_frozen, m_trapped;
  int m_waited, m_stalls, m_flushes;
  logic [7:0] snap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ctrl_now();
    return {hold_IF, hold_ID, hold_EX, flush_ID, flush_EX, bubble_WB, redirect_en, mem_err};
  endfunction

  // Drive one cycle of inputs, check the combinational controls against the
  // model, then advance to the next negedge and check the registered outputs.
  task automatic step(input in_t v, input bit do_rst);
    bit lu, mw, frz, hif, fid, fex, red, old_trap;
    rs1_ID = v.rs1; rs2_ID = v.rs2; dest_EX = v.dest;
    use_rs1_ID = v.u1; use_rs2_ID = v.u2; regwen_EX = v.rw; memread_EX = v.mr;
    branch_taken_EX = v.br; dmem_req_MEM = v.req; dmem_ready = v.rdy;
    rst = do_rst;
    #1;
    snap = ctrl_now();
    if (do_rst) begin
      m_frozen = 0; m_trapped = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
      check("ctrl_in_reset", 32'(snap), 32'd0);
      check("stall_cnt_async_clr", 32'(stall_cnt), 32'd0);
      check("flush_cnt_async_clr", 32'(flush_cnt), 32'd0);
    end else begin
      lu = v.mr && v.rw && v.dest != 0 &&
           ((v.u1 && v.rs1 == v.dest) || (v.u2 && v.rs2 == v.dest));
      mw = v.req && !v.rdy;
      frz = 0; hif = 0; fid = 0; fex = 0; red = 0;
      old_trap = m_trapped;
      if (m_trapped) frz = 1;
      else if (m_frozen && !v.rdy) begin
        frz = 1;
        if (m_waited == TO) m_trapped = 1;
        else m_waited++;
      end else begin
        m_frozen = 0; m_waited = 0;
        if (mw) begin frz = 1; m_frozen = 1; m_waited = 1; end
        else if (v.br) begin fid = 1; fex = 1; red = 1; end
        else if (lu) begin hif = 1; fex = 1; end
      end
      hif = hif | frz;
      check("ctrl", 32'(snap), 32'({hif, frz, frz, fid, fex, frz, red, old_trap}));
      if (hif && m_stalls < SAT) m_stalls++;
      if (red && m_flushes < SAT) m_flushes++;
    end
    @(negedge clk);
    check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
    check("mem_err", 32'(mem_err), 32'(m_trapped));
  endtask

  vec_t tv[8];
  in_t  idle, v;

  initial begin
    idle = '{rs1: 5'd0, rs2: 5'd0, dest: 5'd0, u1: 1'b0, u2: 1'b0,
             rw: 1'b0, mr: 1'b0, br: 1'b0, req: 1'b0, rdy: 1'b0};
    tv[0] = '{"idle",        idle, 8'b0000_0000};
    tv[1] = '{"lu_rs1",      '{5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, 8'b1000_1000};
    tv[2] = '{"lu_rs2",      '{5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, 8'b1000_1000};
    tv[3] = '{"lu_dest0",    '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, 8'b0000_0000};
    tv[4] = '{"lu_unused",   '{5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, 8'b0000_0000};
    tv[5] = '{"no_regwen",   '{5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 8'b0000_0000};
    tv[6] = '{"branch_lu",   '{5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}, 8'b0001_1010};
    tv[7] = '{"mw_over_br",  '{5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}, 8'b1110_0100};

    rst = 1'b1;
    rs1_ID = '0; rs2_ID = '0; dest_EX = '0; use_rs1_ID = 0; use_rs2_ID = 0;
    regwen_EX = 0; memread_EX = 0; branch_taken_EX = 0; dmem_req_MEM = 0; dmem_ready = 0;
    @(negedge clk);
    check("reset_ctrl", 32'(ctrl_now()), 32'd0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);

    // Single-cycle vectors from a freshly reset RUN state
    for (int k = 0; k < 8; k++) begin
      step(idle, 1'b1);
      step(tv[k].i, 1'b0);
      check(tv[k].name, 32'(snap), 32'(tv[k].exp));
    end

    // Load-use gives exactly one bubble
    step(idle, 1'b1);
    step(tv[2].i, 1'b0);
    check("lu_stall", 32'(snap), 32'b1000_1000);
    step(idle, 1'b0);
    check("lu_released", 32'(snap), 32'd0);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Branch with simultaneous load-use
    step(idle, 1'b1);
    step(tv[6].i, 1'b0);
    check("br_lu_flush_cnt", 32'(flush_cnt), 32'd1);

    // Three-cycle dmem wait
    step(idle, 1'b1);
    v = idle; v.req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(v, 1'b0);
      check("mwait_hold", 32'(snap), 32'b1110_0100);
    end
    v.rdy = 1'b1;
    step(v, 1'b0);
    check("mwait_release", 32'(snap), 32'd0);
    check("mwait_stall_cnt", 32'(stall_cnt), 32'd3);
    v = idle; v.req = 1'b1;
    step(v, 1'b0);
    check("back_to_back_wait", 32'(snap), 32'b1110_0100);

    // Deferred branch during a two-cycle wait
    step(idle, 1'b1);
    v = idle; v.req = 1'b1; v.br = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(v, 1'b0);
      check("defer_br_frozen", 32'(snap), 32'b1110_0100);
    end
    v.rdy = 1'b1;
    step(v, 1'b0);
    check("defer_br_ready", 32'(snap), 32'b0001_1010);
    check("defer_br_flush_cnt", 32'(flush_cnt), 32'd1);

    // Timeout into ERR, then asynchronous reset out of it
    step(idle, 1'b1);
    v = idle; v.req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(v, 1'b0);
      if (k == 3) check("timeout_not_yet", 32'(mem_err), 32'd0);
    end
    check("timeout_mem_err", 32'(mem_err), 32'd1);
    v = idle; v.rdy = 1'b1;
    step(v, 1'b0);
    check("err_holds", 32'(snap), 32'b1110_0101);
    step(v, 1'b1);
    check("err_reset_mem_err", 32'(mem_err), 32'd0);

    // Counter saturation under continuous stall
    step(idle, 1'b1);
    for (int k = 0; k < 20; k++) step(tv[1].i, 1'b0);
    check("stall_cnt_saturated", 32'(stall_cnt), 32'd15);

    // Random traffic against the model
    step(idle, 1'b1);
    for (int k = 0; k < 800; k++) begin
      v.rs1  = 5'($urandom_range(0, 3));
      v.rs2  = 5'($urandom_range(0, 3));
      v.dest = 5'($urandom_range(0, 3));
      v.u1   = 1'($urandom_range(0, 1));
      v.u2   = 1'($urandom_range(0, 1));
      v.rw   = 1'($urandom_range(0, 1));
      v.mr   = 1'($urandom_range(0, 1));
      v.br   = ($urandom_range(0, 3) == 0);
      v.req  = 1'($urandom_range(0, 1));
      v.rdy  = 1'($urandom_range(0, 1));
      step(v, $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
